// File: rtl/bus_target.sv
// Memory-side responder for the 65C02 bus: zero-wait on-chip RAM and I/O registers,
// upper-half accesses forwarded over a req/ack port while the core is held with RDY low.
module bus_target #(
    parameter int RAM_AW  = 11,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] AD,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    localparam logic       ST_IDLE   = 1'b0;
    localparam logic       ST_EXT    = 1'b1;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic        state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic        ext_we_q, ext_we_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic [7:0]  scratch_q, scratch_d;
    logic        flag_q, flag_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  wait_q, wait_d;

    logic [7:0]        mem [0:(2**RAM_AW)-1];
    logic [RAM_AW-1:0] ram_idx;
    logic              is_ram, is_io, is_ext, ram_we;
    logic [7:0]        rd_data;

    assign ram_idx = AD[RAM_AW-1:0];
    assign is_ram  = (AD >> RAM_AW) == 16'h0000;
    assign is_io   = AD[15:2] == 14'h3F80;
    assign is_ext  = AD[15] && (AD[15:8] != 8'hFE);
    assign ram_we  = (state_q == ST_IDLE) && is_ram && WE;

    // Everything outside RAM and the four I/O registers reads as 00.
    always_comb begin
        rd_data = 8'h00;
        if (is_ram) begin
            rd_data = mem[ram_idx];
        end else if (is_io) begin
            case (AD[1:0])
                2'd0:    rd_data = scratch_q;
                2'd1:    rd_data = {7'b0, flag_q};
                2'd2:    rd_data = cnt_q[7:0];
                default: rd_data = shadow_q;
            endcase
        end
    end

    // NOTE: every next-state value starts from a default so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        di_d        = di_q;
        ext_addr_d  = ext_addr_q;
        ext_we_d    = ext_we_q;
        ext_wdata_d = ext_wdata_q;
        scratch_d   = scratch_q;
        flag_d      = flag_q;
        shadow_d    = shadow_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q + 16'd1;
        case (state_q)
            ST_IDLE: begin
                if (is_ext) begin
                    ext_addr_d  = AD;
                    ext_we_d    = WE;
                    ext_wdata_d = DO;
                    wait_d      = 8'd1;
                    state_d     = ST_EXT;
                end else begin
                    di_d = rd_data;
                    if (is_io && WE && AD[1:0] == 2'd0) scratch_d = DO;
                    if (is_io && WE && AD[1:0] == 2'd1) flag_d = 1'b0;
                    if (is_io && !WE && AD[1:0] == 2'd2) shadow_d = cnt_q[15:8];
                end
            end
            default: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (ext_ack) begin
                    di_d    = ext_we_q ? 8'h00 : ext_rdata;
                    state_d = ST_IDLE;
                end else if (wait_q == TIMEOUT_C) begin
                    di_d    = 8'hFF;
                    flag_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            di_q        <= 8'h00;
            ext_addr_q  <= 16'h0000;
            ext_we_q    <= 1'b0;
            ext_wdata_q <= 8'h00;
            scratch_q   <= 8'h00;
            flag_q      <= 1'b0;
            cnt_q       <= 16'h0000;
            shadow_q    <= 8'h00;
            wait_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            di_q        <= di_d;
            ext_addr_q  <= ext_addr_d;
            ext_we_q    <= ext_we_d;
            ext_wdata_q <= ext_wdata_d;
            scratch_q   <= scratch_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            wait_q      <= wait_d;
        end
    end

    // NOTE: RAM array has no reset so it maps onto plain memory cells.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= DO;
    end

    assign DI        = di_q;
    assign RDY       = (state_q == ST_IDLE);
    assign ext_req   = (state_q == ST_EXT);
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: RAM, I/O registers, EXT handshake, timeout,
// counter wrap and asynchronous reset during a forwarded access.
module tb_bus_target;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [15:0] AD;
    logic        WE;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        RDY;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] tcnt;
    logic [15:0] exp_cnt;
    int          low_c, req_c, stable;

    bus_target #(.RAM_AW(11), .TIMEOUT(16)) dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .AD        (AD),
        .WE        (WE),
        .DO        (DO),
        .DI        (DI),
        .RDY       (RDY),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; equals the counter value at the next edge.
    always @(posedge clk or negedge RST_N) begin
        if (!RST_N) tcnt <= 16'h0000;
        else        tcnt <= tcnt + 16'd1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One access: present it, let the edge sample it, settle.
    task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        AD = a; WE = w; DO = d; ext_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    // Run an EXT access to completion; ack raised during EXT cycle ack_at (0 = never).
    task automatic ext_run(input int ack_at, input logic [7:0] rd,
                           output int low, output int reqs, output int stab);
        logic [15:0] a0;
        a0   = ext_addr;
        low  = 0;
        reqs = 0;
        stab = 1;
        AD = 16'h0123; WE = 1'b1; DO = 8'hEE;
        for (int i = 1; i <= 40 && RDY == 1'b0; i++) begin
            low++;
            if (ext_req) reqs++;
            if (ext_addr !== a0) stab = 0;
            ext_ack   = (i == ack_at);
            ext_rdata = rd;
            @(posedge clk); #1;
            ext_ack = 1'b0;
        end
    endtask

    initial begin
        RST_N = 1'b0; AD = 16'h0000; WE = 1'b0; DO = 8'h00;
        ext_ack = 1'b0; ext_rdata = 8'h00;
        #12;
        check("rst_di", DI, 8'h00);
        check("rst_rdy", RDY, 1'b1);
        check("rst_req", ext_req, 1'b0);
        check("rst_we", ext_we, 1'b0);
        check("rst_addr", ext_addr, 16'h0000);
        check("rst_wdata", ext_wdata, 8'h00);
        @(negedge clk); RST_N = 1'b1;
        @(posedge clk); #1;

        // RAM write then read, and RAM top boundary
        bus(16'h0123, 1'b1, 8'h5A);
        check("ram_wr_rdy", RDY, 1'b1);
        bus(16'h0123, 1'b0, 8'h00);
        check("ram_rd", DI, 8'h5A);
        check("ram_rd_rdy", RDY, 1'b1);
        bus(16'h0000, 1'b1, 8'h11);
        bus(16'h07FF, 1'b1, 8'hC6);
        bus(16'h0800, 1'b1, 8'h99);
        bus(16'h07FF, 1'b0, 8'h00);
        check("ram_top", DI, 8'hC6);
        bus(16'h0800, 1'b0, 8'h00);
        check("null_0800", DI, 8'h00);
        bus(16'h0000, 1'b0, 8'h00);
        check("ram_no_alias", DI, 8'h11);

        // Scratch and NULL I/O-page addresses
        bus(16'hFE00, 1'b1, 8'hA7);
        bus(16'hFE00, 1'b0, 8'h00);
        check("scratch", DI, 8'hA7);
        bus(16'hFE04, 1'b0, 8'h00);
        check("null_fe04", DI, 8'h00);
        check("null_fe04_rdy", RDY, 1'b1);
        bus(16'hFE80, 1'b0, 8'h00);
        check("null_fe80_rdy", RDY, 1'b1);

        // EXT read, ack in the 3rd EXT cycle
        bus(16'h8000, 1'b0, 8'h00);
        check("ext1_req", ext_req, 1'b1);
        check("ext1_addr", ext_addr, 16'h8000);
        check("ext1_we", ext_we, 1'b0);
        ext_run(3, 8'hC3, low_c, req_c, stable);
        check("ext1_low", 16'(low_c), 16'd3);
        check("ext1_reqc", 16'(req_c), 16'd3);
        check("ext1_stable", 16'(stable), 16'd1);
        check("ext1_di", DI, 8'hC3);
        check("ext1_rdy", RDY, 1'b1);
        check("ext1_req_drop", ext_req, 1'b0);

        // Timeout, status flag, flag clear by write
        bus(16'h9000, 1'b0, 8'h00);
        ext_run(0, 8'h00, low_c, req_c, stable);
        check("to_low", 16'(low_c), 16'd16);
        check("to_di", DI, 8'hFF);
        bus(16'hFE01, 1'b0, 8'h00);
        check("to_flag", DI, 8'h01);
        bus(16'hFE01, 1'b1, 8'h00);
        bus(16'hFE01, 1'b0, 8'h00);
        check("flag_clr", DI, 8'h00);

        // Ack on the timeout edge wins
        bus(16'hC000, 1'b0, 8'h00);
        ext_run(16, 8'h77, low_c, req_c, stable);
        check("ack16_low", 16'(low_c), 16'd16);
        check("ack16_di", DI, 8'h77);
        bus(16'hFE01, 1'b0, 8'h00);
        check("ack16_flag", DI, 8'h00);

        // EXT write, fastest ack; reads back 00
        bus(16'hA5A5, 1'b1, 8'h3C);
        check("extw_addr", ext_addr, 16'hA5A5);
        check("extw_we", ext_we, 1'b1);
        check("extw_wdata", ext_wdata, 8'h3C);
        ext_run(1, 8'h99, low_c, req_c, stable);
        check("extw_low", 16'(low_c), 16'd1);
        check("extw_di", DI, 8'h00);

        // Stray ack in IDLE
        AD = 16'hFE00; WE = 1'b0; ext_ack = 1'b1; ext_rdata = 8'h11;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        check("stray_rdy", RDY, 1'b1);
        check("stray_req", ext_req, 1'b0);
        check("stray_di", DI, 8'hA7);

        // Back-to-back EXT, FF00 is EXT
        bus(16'hFF00, 1'b0, 8'h00);
        check("ff00_req", ext_req, 1'b1);
        ext_run(1, 8'h42, low_c, req_c, stable);
        check("ff00_di", DI, 8'h42);
        bus(16'h8001, 1'b0, 8'h00);
        check("b2b_req", ext_req, 1'b1);
        check("b2b_addr", ext_addr, 16'h8001);
        ext_run(2, 8'h5E, low_c, req_c, stable);
        check("b2b_low", 16'(low_c), 16'd2);
        check("b2b_di", DI, 8'h5E);

        // AD/WE/DO during EXT were ignored
        bus(16'h0123, 1'b0, 8'h00);
        check("ram_kept", DI, 8'h5A);

        // Counter snapshot
        repeat (37) @(posedge clk);
        #1;
        exp_cnt = tcnt;
        bus(16'hFE02, 1'b0, 8'h00);
        check("cnt_lo", DI, {8'h00, exp_cnt[7:0]});
        bus(16'hFE03, 1'b0, 8'h00);
        check("cnt_hi", DI, {8'h00, exp_cnt[15:8]});

        // Counter wrap
        for (int i = 0; i < 70000 && tcnt != 16'hFFFF; i++) begin
            @(posedge clk); #1;
        end
        check("wrap_wait", tcnt, 16'hFFFF);
        bus(16'hFE02, 1'b0, 8'h00);
        check("wrap_lo_ff", DI, 8'hFF);
        bus(16'hFE02, 1'b0, 8'h00);
        check("wrap_lo_00", DI, 8'h00);
        bus(16'hFE03, 1'b0, 8'h00);
        check("wrap_hi_00", DI, 8'h00);

        // Asynchronous reset during EXT
        bus(16'h8000, 1'b0, 8'h00);
        check("mid_req", ext_req, 1'b1);
        @(posedge clk); #2;
        RST_N = 1'b0;
        #1;
        check("arst_req", ext_req, 1'b0);
        check("arst_rdy", RDY, 1'b1);
        check("arst_addr", ext_addr, 16'h0000);
        @(negedge clk); RST_N = 1'b1;
        bus(16'hFE00, 1'b0, 8'h00);
        check("arst_scratch", DI, 8'h00);
        bus(16'h1000, 1'b0, 8'h00);
        check("arst_null", DI, 8'h00);
        check("arst_null_rdy", RDY, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
